pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline-stage register for the core, the successor to the fixed-field inter-stage registers between if/id/ex/mem/wb. It moves one opaque payload word per cycle under a valid/ready handshake. It also honours the ctrl unit's per-stage hold and flush, and inserts a configurable bubble value (NOP) whenever no valid payload is present. An optional second (skid) entry keeps full throughput while cutting the combinational path from downstream ready back to upstream ready.

## Interface
Parameters:
- DW, 32, payload width in bits (≥1).
- NOP_VAL, 32'h0000_0013, value driven on m_data_o when m_valid_o=0. Equals `INST_NOP` for instruction-carrying stages. Width DW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- s_valid_i  in  1  upstream payload valid.
- s_ready_o  out  1  stage can accept this cycle.
- s_data_i  in  DW  upstream payload.
- m_valid_o  out  1  payload presented downstream.
- m_ready_i  in  1  downstream accepts this cycle.
- m_data_o  out  DW  presented payload (NOP_VAL when invalid).
- hold_i  in  1  ctrl stall for this stage (one bit of ctrl's hold vector, selected at instantiation).
- flush_i  in  1  ctrl flush for this stage.
- occ_o  out  2  entries held (0..2).

## Operation
- Storage: main entry (drives m_data_o) and, with skid enabled, skid entry.
- State: EMPTY (occ 0), BUSY (main valid, occ 1), FULL (main+skid valid, occ 2).
- acc = s_valid_i & s_ready_o.
- drn = m_valid_o & m_ready_i & ~hold_i.
- s_ready_o = (state≠FULL) & ~hold_i & ~flush_i.
- m_valid_o = (state≠EMPTY). m_data_o = main when valid, else NOP_VAL.
- Transitions, priority order:
  1. rstn=0 or flush_i=1 → EMPTY, main←NOP_VAL, skid←NOP_VAL; any concurrent acc/drn is discarded.
  2. hold_i=1 → state and entries frozen, no acc, no drn.
  3. Otherwise:
     - EMPTY: acc → BUSY, main←s_data_i.
     - BUSY: acc&drn → BUSY, main←s_data_i. acc&~drn → FULL, skid←s_data_i. ~acc&drn → EMPTY, main←NOP_VAL.
     - FULL: drn → BUSY, main←skid, skid←NOP_VAL. No acc possible.
- Payload ordering is strictly FIFO; no payload is ever dropped except by flush or reset.
- Downstream holding m_ready_i=0 keeps m_valid_o and m_data_o stable (AXI-style: once asserted, valid is not withdrawn except by flush or reset).

## Timing
- Reset outputs: m_valid_o=0, m_data_o=NOP_VAL, occ_o=0, s_ready_o=~hold_i (flush_i is also low at that point).
- Latency: payload accepted in cycle N appears on m_data_o in cycle N+1 when the stage was EMPTY or draining.
- Throughput: 1 payload/cycle sustained while m_ready_i=1.
- Downstream stall: a payload is accepted on the first stall cycle (BUSY→FULL). s_ready_o drops on the next cycle.
- hold_i and flush_i act in the same cycle they are asserted. Flush in the same cycle as hold: flush wins.
- Reset or flush mid-transfer: next cycle is EMPTY regardless of prior state.

## Configuration
- PIPE_SKID_EN defined: two entries, FULL state reachable. s_ready_o does not depend on m_ready_i.
- PIPE_SKID_EN undefined: single entry, FULL unreachable, occ_o ≤ 1, skid register absent.
  - s_ready_o = (~m_valid_o | m_ready_i) & ~hold_i & ~flush_i, a combinational path from m_ready_i.
  - In BUSY, acc&~drn cannot occur.
- All other behaviour is identical in both builds.

## Structure
- State encodings go in defines.v as `PSS_EMPTY=2'd0`, `PSS_BUSY=2'd1`, `PSS_FULL=2'd2`. `INST_NOP` is reused from there as the default NOP_VAL for instruction stages.
- Entries are built from gnrl_dfflr/gnrl_dfflrd instances.
- One sub-module: pipe_skid_fsm. Inputs s_valid_i, m_ready_i, hold_i, flush_i; outputs state, load enables for main and skid, and the skid→main select.

## Test plan
- Reset: rstn=0 for 2 cycles with s_valid_i=1, s_data_i=32'hDEAD_BEEF. → m_valid_o=0, m_data_o=32'h13, occ_o=0 throughout and on the first cycle after release.
- Streaming: 8 back-to-back payloads 1..8 with m_ready_i=1. → outputs 1..8 on consecutive cycles, each one cycle after input, occ_o=1.
- Skid (PIPE_SKID_EN): stream A,B,C. Drop m_ready_i while A is presented. → B captured (occ_o=2), s_ready_o=0, C held upstream. Raise m_ready_i → A, B, C delivered in order, no loss.
- Hold: assert hold_i for 3 cycles while FULL. → m_data_o, occ_o frozen; s_ready_o=0; no drn even with m_ready_i=1.
- Flush: flush_i=1 while FULL with s_valid_i=1. → next cycle m_valid_o=0, m_data_o=NOP_VAL, occ_o=0; incoming payload not captured.
- No-skid build: same stall as the skid scenario. → s_ready_o follows m_ready_i combinationally; occ_o never exceeds 1; order preserved.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared state/source encodings for pipe_skid_stage.
// Build option: define PIPE_SKID_EN to enable the second (skid) entry.
package pipe_skid_stage_pkg;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      PSS_EMPTY = 2'd0,
      PSS_BUSY  = 2'd1,
      PSS_FULL  = 2'd2
   } pss_state_e;

   // What an entry loads when its load enable is high.
   typedef enum logic [1:0] {
      SRC_NOP  = 2'd0,
      SRC_IN   = 2'd1,
      SRC_SKID = 2'd2
   } pss_src_e;

   function automatic logic [1:0] pssOcc(input logic [1:0] st);
      logic [1:0] occ;
      occ = 2'd0;
      if (st == PSS_BUSY) occ = 2'd1;
      if (st == PSS_FULL) occ = 2'd2;
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_fsm.sv
// Handshake/control FSM for pipe_skid_stage: state, ready/valid and entry load controls.
// Build option: PIPE_SKID_EN adds the FULL state and the skid-entry controls.
module pipe_skid_fsm
   import pipe_skid_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       s_valid_i,
   input  logic       m_ready_i,
   input  logic       hold_i,
   input  logic       flush_i,
   output logic [1:0] state_o,
   output logic       s_ready_o,
   output logic       m_valid_o,
   output logic       main_le_o,
   output logic [1:0] main_sel_o
`ifdef PIPE_SKID_EN
   ,
   output logic       skid_le_o,
   output logic [1:0] skid_sel_o
`endif
);

   pss_state_e r_state;
   pss_state_e w_stateNext;
   logic       w_acc;
   logic       w_drn;
   logic       w_sReady;
   logic       w_mValid;
   logic       w_mainLe;
   pss_src_e   w_mainSel;
`ifdef PIPE_SKID_EN
   logic       w_skidLe;
   pss_src_e   w_skidSel;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= PSS_EMPTY;
      else       r_state <= w_stateNext;
   end

   assign w_mValid = (r_state != PSS_EMPTY);
`ifdef PIPE_SKID_EN
   assign w_sReady = (r_state != PSS_FULL) & ~hold_i & ~flush_i;
`else
   // Single entry: can only refill in the same cycle the current word leaves.
   assign w_sReady = (~w_mValid | m_ready_i) & ~hold_i & ~flush_i;
`endif
   assign w_acc = s_valid_i & w_sReady;
   assign w_drn = w_mValid & m_ready_i & ~hold_i;

   // Flush beats hold; hold freezes everything; otherwise move per state.
   always_comb begin
      w_stateNext = r_state;
      w_mainLe    = 1'b0;
      w_mainSel   = SRC_NOP;
`ifdef PIPE_SKID_EN
      w_skidLe    = 1'b0;
      w_skidSel   = SRC_NOP;
`endif
      if (flush_i) begin
         w_stateNext = PSS_EMPTY;
         w_mainLe    = 1'b1;
`ifdef PIPE_SKID_EN
         w_skidLe    = 1'b1;
`endif
      end else if (!hold_i) begin
         case (r_state)
            PSS_EMPTY: begin
               if (w_acc) begin
                  w_stateNext = PSS_BUSY;
                  w_mainLe    = 1'b1;
                  w_mainSel   = SRC_IN;
               end
            end
            PSS_BUSY: begin
               if (w_acc && w_drn) begin
                  w_mainLe  = 1'b1;
                  w_mainSel = SRC_IN;
               end
`ifdef PIPE_SKID_EN
               else if (w_acc) begin
                  w_stateNext = PSS_FULL;
                  w_skidLe    = 1'b1;
                  w_skidSel   = SRC_IN;
               end
`endif
               else if (w_drn) begin
                  w_stateNext = PSS_EMPTY;
                  w_mainLe    = 1'b1;
               end
            end
`ifdef PIPE_SKID_EN
            PSS_FULL: begin
               if (w_drn) begin
                  w_stateNext = PSS_BUSY;
                  w_mainLe    = 1'b1;
                  w_mainSel   = SRC_SKID;
                  w_skidLe    = 1'b1;
               end
            end
`endif
            default: begin
               w_stateNext = PSS_EMPTY;
               w_mainLe    = 1'b1;
            end
         endcase
      end
   end

   assign state_o    = r_state;
   assign s_ready_o  = w_sReady;
   assign m_valid_o  = w_mValid;
   assign main_le_o  = w_mainLe;
   assign main_sel_o = w_mainSel;
`ifdef PIPE_SKID_EN
   assign skid_le_o  = w_skidLe;
   assign skid_sel_o = w_skidSel;
`endif

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with ctrl hold/flush and NOP bubble insertion.
// Build option: PIPE_SKID_EN adds a skid entry so s_ready_o no longer depends on m_ready_i.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int            DW      = 32,
   parameter logic [DW-1:0] NOP_VAL = DW'(INST_NOP)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          s_valid_i,
   output logic          s_ready_o,
   input  logic [DW-1:0] s_data_i,
   output logic          m_valid_o,
   input  logic          m_ready_i,
   output logic [DW-1:0] m_data_o,
   input  logic          hold_i,
   input  logic          flush_i,
   output logic [1:0]    occ_o
);

   logic [DW-1:0] r_main;
   logic [1:0]    w_state;
   logic          w_mValid;
   logic          w_mainLe;
   logic [1:0]    w_mainSel;
`ifdef PIPE_SKID_EN
   logic [DW-1:0] r_skid;
   logic          w_skidLe;
   logic [1:0]    w_skidSel;
`endif

   pipe_skid_fsm u_fsm (
      .clk        (clk),
      .rstn       (rstn),
      .s_valid_i  (s_valid_i),
      .m_ready_i  (m_ready_i),
      .hold_i     (hold_i),
      .flush_i    (flush_i),
      .state_o    (w_state),
      .s_ready_o  (s_ready_o),
      .m_valid_o  (w_mValid),
      .main_le_o  (w_mainLe),
      .main_sel_o (w_mainSel)
`ifdef PIPE_SKID_EN
      ,
      .skid_le_o  (w_skidLe),
      .skid_sel_o (w_skidSel)
`endif
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_main <= NOP_VAL;
      end else if (w_mainLe) begin
         case (w_mainSel)
            SRC_IN:   r_main <= s_data_i;
`ifdef PIPE_SKID_EN
            SRC_SKID: r_main <= r_skid;
`endif
            default:  r_main <= NOP_VAL;
         endcase
      end
   end

`ifdef PIPE_SKID_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_skid <= NOP_VAL;
      end else if (w_skidLe) begin
         if (w_skidSel == SRC_IN) r_skid <= s_data_i;
         else                     r_skid <= NOP_VAL;
      end
   end
`endif

   assign m_valid_o = w_mValid;
   assign m_data_o  = w_mValid ? r_main : NOP_VAL;
   assign occ_o     = pssOcc(w_state);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a FIFO model tracks accepted payloads and
// every cycle's outputs are compared against it. Works with or without PIPE_SKID_EN.
module tb_pipe_skid_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [31:0] s_data_i;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [31:0] m_data_o;
   logic        hold_i;
   logic        flush_i;
   logic [1:0]  occ_o;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] srcQ[$];
   logic [31:0] expQ[$];

   always #5 clk = ~clk;

   pipe_skid_stage dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .s_data_i  (s_data_i),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_data_o  (m_data_o),
      .hold_i    (hold_i),
      .flush_i   (flush_i),
      .occ_o     (occ_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, check at negedge against the model, then advance the model.
   task automatic applyStimulus(input bit offer, input bit mr, input bit hd, input bit fl);
      logic expReady;
      bit   acc;
      bit   drn;
      s_valid_i = offer && (srcQ.size() > 0);
      s_data_i  = s_valid_i ? srcQ[0] : $urandom;
      m_ready_i = mr;
      hold_i    = hd;
      flush_i   = fl;
      @(negedge clk);
      if (SKID) expReady = (expQ.size() < 2) && !hd && !fl;
      else      expReady = ((expQ.size() == 0) || mr) && !hd && !fl;
      checkOutput("s_ready", {31'b0, s_ready_o}, {31'b0, expReady});
      checkOutput("m_valid", {31'b0, m_valid_o}, (expQ.size() != 0) ? 32'd1 : 32'd0);
      checkOutput("m_data", m_data_o, (expQ.size() != 0) ? expQ[0] : NOP);
      checkOutput("occ", {30'b0, occ_o}, expQ.size());
      if (!rstn || fl) begin
         expQ.delete();
      end else if (!hd) begin
         drn = (expQ.size() > 0) && mr;
         acc = s_valid_i && expReady;
         if (drn) void'(expQ.pop_front());
         if (acc) expQ.push_back(srcQ.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn      = 1'b0;
      s_valid_i = 1'b0;
      s_data_i  = 32'h0;
      m_ready_i = 1'b0;
      hold_i    = 1'b0;
      flush_i   = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] reset with upstream valid");
      srcQ.push_back(32'hDEAD_BEEF);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      srcQ.delete();
      rstn = 1'b1;
      applyStimulus(0, 1, 0, 0);

      $display("[TB] streaming 1..8");
      for (int i = 1; i <= 8; i++) srcQ.push_back(i);
      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);

      $display("[TB] downstream stall A,B,C");
      srcQ.push_back(32'hA); srcQ.push_back(32'hB); srcQ.push_back(32'hC);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);

      $display("[TB] hold while full");
      srcQ.push_back(32'hD0); srcQ.push_back(32'hE0); srcQ.push_back(32'hF0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);

      $display("[TB] flush while full, then flush with hold");
      srcQ.push_back(32'h111); srcQ.push_back(32'h222); srcQ.push_back(32'h333);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 1, 1);
      applyStimulus(0, 1, 0, 0);
      srcQ.delete();

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         while (srcQ.size() < 3) srcQ.push_back($urandom);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
